// File: rtl/dut_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dut_stream_sequencer
// Purpose  : Runs one sampler job in the crypto_clk domain. It streams
//            nwords host words to the DUT over VALID/READY, then collects
//            nbeats packed output beats into the host sample buffer.
//            It reports busy, a one-cycle done pulse and a completion status.
// Options  : SEQ_TIMEOUT_EN - when defined, a SEND/RECV stall of pTIMEOUT
//            cycles ends the job with status 10.
// Revision : 1.0 - initial release
// ============================================================================
module dut_stream_sequencer #(
    parameter int pW        = 64,
    parameter int pOUTPUT_W = 4,
    parameter int pCOEFF_W  = 23,
    parameter int pCNT_W    = 8,
    parameter int pTIMEOUT  = 1024
) (
    input  logic                          crypto_clk,
    input  logic                          reset_i,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic [pCNT_W-1:0]             i_nwords,
    input  logic [pCNT_W-1:0]             i_nbeats,
    output logic [pCNT_W-1:0]             o_word_idx,
    input  logic [pW-1:0]                 i_word,
    output logic                          o_dut_valid,
    input  logic                          i_dut_ready,
    output logic [pW-1:0]                 o_dut_data,
    input  logic                          i_dut_valid,
    output logic                          o_dut_ready,
    input  logic [pOUTPUT_W*pCOEFF_W-1:0] i_dut_samples,
    output logic                          o_smp_we,
    output logic [pCNT_W-1:0]             o_smp_idx,
    output logic [pOUTPUT_W*pCOEFF_W-1:0] o_smp_data,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [1:0]                    o_status
);

    localparam int         c_smp_w        = pOUTPUT_W * pCOEFF_W;
    localparam logic [1:0] c_stat_ok      = 2'b00;
    localparam logic [1:0] c_stat_abort   = 2'b01;
    localparam logic [1:0] c_stat_timeout = 2'b10;
    localparam logic [1:0] c_stat_reject  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_RECV = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    logic [pCNT_W-1:0]   r_nwords;
    logic [pCNT_W-1:0]   r_nbeats;
    logic [pCNT_W-1:0]   r_word_cnt;
    logic [pCNT_W-1:0]   r_beat_cnt;
    logic                r_dut_valid;
    logic                r_dut_ready;
    logic [pW-1:0]       r_dut_data;
    logic                r_smp_we;
    logic [pCNT_W-1:0]   r_smp_idx;
    logic [c_smp_w-1:0]  r_smp_data;
    logic                r_busy;
    logic                r_done;
    logic [1:0]          r_status;

    // Abort is honoured only while a job is actually moving data.
    logic w_abort;
    assign w_abort = i_abort && ((r_state == S_LOAD) || (r_state == S_SEND) || (r_state == S_RECV));

    // A stall cycle is a SEND/RECV cycle in which the relevant handshake did not happen.
    logic w_stall;
    assign w_stall = ((r_state == S_SEND) && !i_dut_ready) || ((r_state == S_RECV) && !i_dut_valid);

    logic w_stall_hit;
`ifdef SEQ_TIMEOUT_EN
    localparam int c_stall_w = $clog2(pTIMEOUT + 1);
    logic [c_stall_w-1:0] r_stall;

    assign w_stall_hit = w_stall && (r_stall == c_stall_w'(pTIMEOUT - 1));

    // Stall counter: runs on stall cycles, restarts on any handshake or state change.
    always_ff @(posedge crypto_clk) begin
        if (reset_i || !w_stall) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + c_stall_w'(1);
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (pTIMEOUT > 0) && w_stall;
    assign w_stall_hit      = 1'b0;
`endif

    // Job sequencer: state, counters and all registered outputs.
    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_nwords    <= '0;
            r_nbeats    <= '0;
            r_word_cnt  <= '0;
            r_beat_cnt  <= '0;
            r_dut_valid <= 1'b0;
            r_dut_ready <= 1'b0;
            r_dut_data  <= '0;
            r_smp_we    <= 1'b0;
            r_smp_idx   <= '0;
            r_smp_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= c_stat_ok;
        end else begin
            r_done   <= 1'b0;
            r_smp_we <= 1'b0;
            if (w_abort || w_stall_hit) begin
                // Abort wins over a handshake landing on the same edge.
                r_dut_valid <= 1'b0;
                r_dut_ready <= 1'b0;
                r_status    <= w_abort ? c_stat_abort : c_stat_timeout;
                r_done      <= 1'b1;
                r_state     <= S_DONE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            if (i_nwords != '0) begin
                                r_nwords   <= i_nwords;
                                r_nbeats   <= i_nbeats;
                                r_word_cnt <= '0;
                                r_beat_cnt <= '0;
                                r_status   <= c_stat_ok;
                                r_busy     <= 1'b1;
                                r_state    <= S_LOAD;
                            end else begin
                                r_status <= c_stat_reject;
                                r_done   <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_dut_data  <= i_word;
                        r_dut_valid <= 1'b1;
                        r_state     <= S_SEND;
                    end
                    S_SEND: begin
                        if (i_dut_ready) begin
                            r_dut_valid <= 1'b0;
                            r_word_cnt  <= r_word_cnt + pCNT_W'(1);
                            if (r_word_cnt == r_nwords - pCNT_W'(1)) begin
                                if (r_nbeats == '0) begin
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_dut_ready <= 1'b1;
                                    r_state     <= S_RECV;
                                end
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                    S_RECV: begin
                        if (i_dut_valid) begin
                            r_smp_we   <= 1'b1;
                            r_smp_idx  <= r_beat_cnt;
                            r_smp_data <= i_dut_samples;
                            r_beat_cnt <= r_beat_cnt + pCNT_W'(1);
                            if (r_beat_cnt == r_nbeats - pCNT_W'(1)) begin
                                r_dut_ready <= 1'b0;
                                r_done      <= 1'b1;
                                r_state     <= S_DONE;
                            end
                        end
                    end
                    S_DONE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_word_idx  = r_word_cnt;
    assign o_dut_valid = r_dut_valid;
    assign o_dut_data  = r_dut_data;
    assign o_dut_ready = r_dut_ready;
    assign o_smp_we    = r_smp_we;
    assign o_smp_idx   = r_smp_idx;
    assign o_smp_data  = r_smp_data;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_status    = r_status;

endmodule
`default_nettype wire

// File: tb/tb_dut_stream_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dut_stream_sequencer
// Purpose  : Directed self-checking bench for dut_stream_sequencer.
//            Build with SEQ_TIMEOUT_EN to cover the stall timeout path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dut_stream_sequencer;

    localparam int c_w    = 64;
    localparam int c_ow   = 4;
    localparam int c_cw   = 23;
    localparam int c_cntw = 8;
    localparam int c_sw   = c_ow * c_cw;

    logic              clk;
    logic              rst;
    logic              start;
    logic              abort;
    logic [c_cntw-1:0] nwords;
    logic [c_cntw-1:0] nbeats;
    logic [c_cntw-1:0] word_idx;
    logic [c_w-1:0]    word;
    logic              dut_valid;
    logic              dut_ready_in;
    logic [c_w-1:0]    dut_data;
    logic              dut_valid_in;
    logic              dut_ready;
    logic [c_sw-1:0]   dut_samples;
    logic              smp_we;
    logic [c_cntw-1:0] smp_idx;
    logic [c_sw-1:0]   smp_data;
    logic              busy;
    logic              done;
    logic [1:0]        status;

    int checks   = 0;
    int failures = 0;

    // Monitor records (never cleared; tests use base snapshots)
    logic [c_w-1:0]    hs_q[$];
    logic [c_cntw-1:0] idx_q[$];
    logic [c_sw-1:0]   dat_q[$];
    int                done_cnt  = 0;
    int                valid_cyc = 0;
    int                src_beat  = 0;

    dut_stream_sequencer #(
        .pW(c_w), .pOUTPUT_W(c_ow), .pCOEFF_W(c_cw), .pCNT_W(c_cntw), .pTIMEOUT(16)
    ) u_dut (
        .crypto_clk    (clk),
        .reset_i       (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_nwords      (nwords),
        .i_nbeats      (nbeats),
        .o_word_idx    (word_idx),
        .i_word        (word),
        .o_dut_valid   (dut_valid),
        .i_dut_ready   (dut_ready_in),
        .o_dut_data    (dut_data),
        .i_dut_valid   (dut_valid_in),
        .o_dut_ready   (dut_ready),
        .i_dut_samples (dut_samples),
        .o_smp_we      (smp_we),
        .o_smp_idx     (smp_idx),
        .o_smp_data    (smp_data),
        .o_busy        (busy),
        .o_done        (done),
        .o_status      (status)
    );

    function automatic logic [c_w-1:0] host_word(input logic [c_cntw-1:0] idx);
        return {32'hC0DE_5EED, 24'h00_0000, idx};
    endfunction

    function automatic logic [c_sw-1:0] samp_pat(input int k);
        logic [c_sw-1:0] v;
        v = '0;
        for (int j = 0; j < c_ow; j++) v[j*c_cw +: c_cw] = c_cw'(32'h0001_A000 + k * 16 + j);
        return v;
    endfunction

    assign word        = host_word(word_idx);
    assign dut_samples = samp_pat(src_beat);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Host-side DUT model: next beat offered after each accepted beat.
    always @(posedge clk) begin
        if (start && !busy)               src_beat <= 0;
        else if (dut_ready && dut_valid_in) src_beat <= src_beat + 1;
    end

    // Observe interface traffic away from the active edge.
    always @(negedge clk) begin
        if (dut_valid && dut_ready_in) hs_q.push_back(dut_data);
        if (dut_valid) valid_cyc++;
        if (smp_we) begin
            idx_q.push_back(smp_idx);
            dat_q.push_back(smp_data);
        end
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic start_job(input int nw, input int nb);
        @(posedge clk); #1;
        start  = 1'b1;
        nwords = c_cntw'(nw);
        nbeats = c_cntw'(nb);
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        logic got;
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, got, 1'b1);
    endtask

    // sel 0: wait for o_dut_valid, sel 1: wait for o_dut_ready
    task automatic wait_out(input string tag, input int sel, input int bound);
        logic got;
        got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((sel == 0) ? dut_valid : dut_ready) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, got, 1'b1);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #1;
    endtask

    int hb, ib, db, vb;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; nwords = '0; nbeats = '0;
        dut_ready_in = 1'b0; dut_valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy",   busy,      1'b0);
        check("rst_done",   done,      1'b0);
        check("rst_status", status,    2'b00);
        check("rst_valid",  dut_valid, 1'b0);
        check("rst_ready",  dut_ready, 1'b0);
        check("rst_we",     smp_we,    1'b0);
        check("rst_widx",   word_idx,  8'd0);

        // Basic job: 2 words, 3 beats, everything always ready
        dut_ready_in = 1'b1; dut_valid_in = 1'b1;
        hb = hs_q.size(); ib = idx_q.size(); db = done_cnt;
        start_job(2, 3);
        wait_done("basic_done", 60);
        settle();
        check("basic_hs_n",  hs_q.size() - hb, 2);
        check("basic_w0",    hs_q[hb],     host_word(8'd0));
        check("basic_w1",    hs_q[hb + 1], host_word(8'd1));
        check("basic_wr_n",  idx_q.size() - ib, 3);
        for (int k = 0; k < 3; k++) begin
            check("basic_idx", idx_q[ib + k], c_cntw'(k));
            check("basic_dat", dat_q[ib + k], samp_pat(k));
        end
        check("basic_done_n", done_cnt - db, 1);
        check("basic_status", status, 2'b00);
        check("basic_busy",   busy,   1'b0);

        // Backpressure: ready low for 5 SEND cycles
        dut_ready_in = 1'b0;
        hb = hs_q.size(); ib = idx_q.size(); db = done_cnt;
        start_job(1, 0);
        wait_out("stall_valid_seen", 0, 20);
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", dut_valid, 1'b1);
            check("stall_data",  dut_data,  host_word(8'd0));
            @(negedge clk);
        end
        @(posedge clk); #1 dut_ready_in = 1'b1;
        wait_done("stall_done", 20);
        settle();
        check("stall_hs_n",   hs_q.size() - hb, 1);
        check("stall_hs_w",   hs_q[hb], host_word(8'd0));
        check("stall_wr_n",   idx_q.size() - ib, 0);
        check("stall_done_n", done_cnt - db, 1);

        // Zero-word request is rejected
        vb = valid_cyc; db = done_cnt;
        start_job(0, 3);
        settle();
        check("rej_status", status, 2'b11);
        check("rej_done_n", done_cnt - db, 1);
        check("rej_valid",  valid_cyc - vb, 0);
        check("rej_busy",   busy, 1'b0);
        start_job(1, 1);
        @(negedge clk);
        check("rej_clear_status", status, 2'b00);
        check("rej_clear_busy",   busy,   1'b1);
        wait_done("rej_next_done", 30);
        settle();

        // Abort in RECV after one of four beats
        dut_valid_in = 1'b0;
        ib = idx_q.size(); db = done_cnt;
        start_job(1, 4);
        wait_out("abort_recv_seen", 1, 20);
        @(posedge clk); #1 dut_valid_in = 1'b1;
        @(posedge clk); #1 dut_valid_in = 1'b0;
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_done("abort_done", 10);
        check("abort_status", status,    2'b01);
        check("abort_ready",  dut_ready, 1'b0);
        settle();
        check("abort_wr_n",   idx_q.size() - ib, 1);
        check("abort_wr_dat", dat_q[ib], samp_pat(0));
        check("abort_done_n", done_cnt - db, 1);
        check("abort_busy",   busy, 1'b0);
        dut_valid_in = 1'b1;
        ib = idx_q.size();
        start_job(1, 1);
        wait_done("abort_next_done", 30);
        settle();
        check("abort_next_status", status, 2'b00);
        check("abort_next_wr_n",   idx_q.size() - ib, 1);
        check("abort_next_idx",    idx_q[ib], 8'd0);

        // Start while busy is ignored
        dut_ready_in = 1'b0;
        hb = hs_q.size(); ib = idx_q.size(); db = done_cnt;
        start_job(2, 2);
        wait_out("busy_valid_seen", 0, 20);
        start_job(5, 7);
        @(posedge clk); #1 dut_ready_in = 1'b1;
        wait_done("busy_done", 60);
        settle();
        check("busy_hs_n",   hs_q.size() - hb, 2);
        check("busy_wr_n",   idx_q.size() - ib, 2);
        check("busy_last",   idx_q[ib + 1], 8'd1);
        check("busy_widx",   word_idx, 8'd2);
        check("busy_done_n", done_cnt - db, 1);

        // DUT never ready
        dut_ready_in = 1'b0;
        vb = valid_cyc; hb = hs_q.size();
        start_job(1, 1);
`ifdef SEQ_TIMEOUT_EN
        wait_done("tmo_done", 100);
        check("tmo_status", status, 2'b10);
        settle();
        check("tmo_stall_cycles", valid_cyc - vb, 16);
        check("tmo_busy", busy, 1'b0);
`else
        repeat (1000) @(negedge clk);
        check("notmo_busy",  busy,      1'b1);
        check("notmo_valid", dut_valid, 1'b1);
        check("notmo_hs_n",  hs_q.size() - hb, 0);
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        wait_done("notmo_abort_done", 10);
        check("notmo_status", status,    2'b01);
        check("notmo_valid0", dut_valid, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
